// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmit path:
// FSM encoding, keyboard command bytes and device reply codes.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] REPLY_ACK    = 8'hFA;
    localparam logic [7:0] REPLY_RESEND = 8'hFE;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus debounce for one PS/2 line.
// Idle level is high, so everything resets to 1.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line,
    output logic level
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // A new level is taken only after FILTER_LEN consecutive samples disagree
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], line};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame,
// device ACK check and frame timeout, open-drain line control.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bitcnt, bitcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          parity, parity_n;
    logic          dat_q, dat_n;
    logic          ack_ok, ack_n;
    logic          done_q, done_n;
    logic          err_q, err_n;

    logic clk_f, dat_f, clk_prev;
    logic fall, timed, expire;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .line    (ps2_clk_i),
        .level   (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .line    (ps2_dat_i),
        .level   (dat_f)
    );

    assign fall   = clk_prev & ~clk_f;
    assign timed  = (state == RTS) || (state == SEND) ||
                    (state == ACK) || (state == WAIT_IDLE);
    assign expire = timed && (cnt == CW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            parity   <= 1'b0;
            dat_q    <= 1'b0;
            ack_ok   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            clk_prev <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bitcnt   <= bitcnt_n;
            shreg    <= shreg_n;
            parity   <= parity_n;
            dat_q    <= dat_n;
            ack_ok   <= ack_n;
            done_q   <= done_n;
            err_q    <= err_n;
            clk_prev <= clk_f;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        parity_n = parity;
        dat_n    = dat_q;
        ack_n    = ack_ok;
        done_n   = 1'b0;
        err_n    = 1'b0;

        if (timed) begin
            cnt_n = cnt - 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (tx_valid) begin
                    shreg_n  = tx_data;
                    parity_n = odd_parity(tx_data);
                    cnt_n    = CW'(INHIBIT_CYCLES - 1);
                    state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == '0) begin
                    cnt_n   = CW'(TIMEOUT_CYCLES);
                    state_n = RTS;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RTS: begin
                bitcnt_n = '0;
                dat_n    = 1'b1;
                state_n  = SEND;
            end
            SEND: begin
                if (fall) begin
                    bitcnt_n = bitcnt + 4'd1;
                    if (!bitcnt[3]) begin
                        dat_n = ~shreg[bitcnt[2:0]];
                    end else if (bitcnt == 4'd8) begin
                        dat_n = ~parity;
                    end else begin
                        dat_n   = 1'b0;
                        state_n = ACK;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    ack_n   = ~dat_f;
                    state_n = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_f && dat_f) begin
                    state_n = IDLE;
                    done_n  = ack_ok;
                    err_n   = ~ack_ok;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Timeout overrides any completion seen in the same cycle
        if (expire) begin
            state_n = IDLE;
            dat_n   = 1'b0;
            done_n  = 1'b0;
            err_n   = 1'b1;
        end
    end

    assign tx_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign tx_done    = done_q;
    assign tx_error   = err_q;
    assign ps2_clk_oe = (state == INHIBIT);
    assign ps2_dat_oe = ((state == INHIBIT) && (cnt == '0)) ||
                        (state == RTS) ||
                        ((state == SEND) && dat_q);

endmodule
